// File: rtl/i2c_adc_responder.sv
// I2C target that serves a 12-bit conversion value as two read bytes and
// captures a one-byte configuration register from master writes.
module i2c_adc_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] sample_data,
  output logic [7:0]  cfg_data,
  output logic        cfg_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic [SYNC_STAGES:0]   arm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      arm_q      <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
      arm_q      <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic scl_s, sda_s, armed, start_det, stop_det, scl_rise, scl_fall;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  // Bus conditions are ignored until the preset values have been flushed out
  // of the synchronizer and history flops, so reset release never fakes one.
  assign armed     = arm_q[SYNC_STAGES];
  assign start_det = armed & scl_s & sda_hist_q & ~sda_s;
  assign stop_det  = armed & scl_s & ~sda_hist_q & sda_s;
  assign scl_rise  = armed & scl_s & ~scl_hist_q;
  assign scl_fall  = armed & ~scl_s & scl_hist_q;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sr_q, sr_d;
  logic        ph_q, ph_d;
  logic        rw_q, rw_d;
  logic        byte_q, byte_d;
  logic [11:0] shadow_q, shadow_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  cfg_data_q, cfg_data_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      sr_q        <= 7'd0;
      ph_q        <= 1'b0;
      rw_q        <= 1'b0;
      byte_q      <= 1'b0;
      shadow_q    <= 12'h000;
      sda_oe_q    <= 1'b0;
      cfg_data_q  <= 8'h00;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ph_q        <= ph_d;
      rw_q        <= rw_d;
      byte_q      <= byte_d;
      shadow_q    <= shadow_d;
      sda_oe_q    <= sda_oe_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      busy_q      <= busy_d;
    end
  end

  logic [7:0] byte_full, tx_byte;
  assign byte_full = {sr_q, sda_s};
  assign tx_byte   = byte_q ? shadow_q[7:0] : {4'b0000, shadow_q[11:8]};

  // ph_q marks the ACK slot half: 0 before its SCL rise, 1 after.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ph_d        = ph_q;
    rw_d        = rw_q;
    byte_d      = byte_q;
    shadow_d    = shadow_q;
    sda_oe_d    = sda_oe_q;
    cfg_data_d  = cfg_data_q;
    cfg_valid_d = 1'b0;
    busy_d      = busy_q;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sr_d  = byte_full[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_full[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              ph_d    = 1'b0;
              rw_d    = byte_full[0];
              busy_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: if (scl_rise) begin
          ph_d = 1'b1;
        end else if (scl_fall) begin
          if (!ph_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            state_d  = RD_DATA;
            shadow_d = sample_data;
            byte_d   = 1'b0;
            sda_oe_d = 1'b1;  // byte 0 MSB is always 0
          end else begin
            state_d  = WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
        WR_DATA: if (scl_rise) begin
          sr_d  = byte_full[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d     = WR_ACK;
            ph_d        = 1'b0;
            cfg_data_d  = byte_full;
            cfg_valid_d = 1'b1;
          end
        end
        WR_ACK: if (scl_rise) begin
          ph_d = 1'b1;
        end else if (scl_fall) begin
          if (!ph_q) begin
            sda_oe_d = 1'b1;
          end else begin
            state_d  = WR_DATA;
            sda_oe_d = 1'b0;
          end
        end
        RD_DATA: if (scl_rise) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = RD_ACK;
            ph_d    = 1'b0;
          end
        end else if (scl_fall) begin
          sda_oe_d = ~tx_byte[3'd7 - cnt_q];
        end
        RD_ACK: if (scl_rise) begin
          if (sda_s) state_d = WAIT_STOP;
          else       ph_d    = 1'b1;
        end else if (scl_fall) begin
          if (!ph_q) begin
            sda_oe_d = 1'b0;
          end else begin
            state_d = RD_DATA;
            if (byte_q) begin
              byte_d   = 1'b0;
              shadow_d = sample_data;
              sda_oe_d = 1'b1;
            end else begin
              byte_d   = 1'b1;
              sda_oe_d = ~shadow_q[7];
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Directed bench: bit-level I2C master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_i2c_adc_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic [11:0] sample_data = 12'h000;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        busy;
  logic        sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_adc_responder #(.DEV_ADDR(7'h48), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .sample_data(sample_data), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vld_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (cfg_valid) vld_cnt++;
    if (sda_oe)    oe_cnt++;
    if (busy)      busy_cnt++;
  end

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start;
    #50 sda_m = 1'b1;
    #150 scl = 1'b1;
    #200 sda_m = 1'b0;
    #200 scl = 1'b0;
  endtask

  task automatic i2c_stop;
    #50 sda_m = 1'b0;
    #150 scl = 1'b1;
    #200 sda_m = 1'b1;
    #200;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      #50 sda_m = b[i];
      #150 scl = 1'b1;
      #200 scl = 1'b0;
    end
    #50 sda_m = 1'b1;
    #150 scl = 1'b1;
    #100 ack = ~sda_line;
    #100 scl = 1'b0;
  endtask

  task automatic rd_bit(output logic v);
    #50 sda_m = 1'b1;
    #150 scl = 1'b1;
    #100 v = sda_line;
    #100 scl = 1'b0;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) rd_bit(b[i]);
    #50 sda_m = ~mack;
    #150 scl = 1'b1;
    #200 scl = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack, a2, v;
    logic [7:0] b0, b1, b2, b3, b4;
    int         base_v, base_oe, base_b;

    // reset state
    #52;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_cfg_data", cfg_data, 8'h00);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_busy", busy, 0);
    #50 rst = 1'b1;
    #300;
    chk("idle_oe", oe_cnt, 0);

    // write 0x03
    base_v = vld_cnt;
    i2c_start;
    wr_byte(8'h90, ack);
    chk("wr_addr_ack", ack, 1);
    #1 chk("wr_busy", busy, 1);
    wr_byte(8'h03, a2);
    chk("wr_data_ack", a2, 1);
    i2c_stop;
    chk("wr_cfg", cfg_data, 8'h03);
    chk("wr_pulses", vld_cnt - base_v, 1);
    chk("wr_busy_after", busy, 0);

    // read 0xA5C
    sample_data = 12'hA5C;
    i2c_start;
    wr_byte(8'h91, ack);
    chk("rd_addr_ack", ack, 1);
    rd_byte(1'b1, b0);
    rd_byte(1'b0, b1);
    chk("rd_b0", b0, 8'h0A);
    chk("rd_b1", b1, 8'h5C);
    #100 chk("rd_released", sda_oe, 0);
    i2c_stop;
    chk("rd_busy_after", busy, 0);

    // streaming read with sample change during byte 0
    sample_data = 12'h123;
    i2c_start;
    wr_byte(8'h91, ack);
    chk("st_addr_ack", ack, 1);
    fork
      rd_byte(1'b1, b0);
      begin #1500 sample_data = 12'h456; end
    join
    rd_byte(1'b1, b1);
    rd_byte(1'b1, b2);
    rd_byte(1'b1, b3);
    rd_byte(1'b0, b4);
    i2c_stop;
    chk("st_b0", b0, 8'h01);
    chk("st_b1", b1, 8'h23);
    chk("st_b2", b2, 8'h04);
    chk("st_b3", b3, 8'h56);
    chk("st_b4", b4, 8'h04);

    // wrong address
    base_oe = oe_cnt;
    base_b  = busy_cnt;
    i2c_start;
    wr_byte(8'hA0, ack);
    chk("wa_nack", ack, 0);
    i2c_stop;
    chk("wa_oe_cycles", oe_cnt - base_oe, 0);
    chk("wa_busy_cycles", busy_cnt - base_b, 0);
    chk("wa_cfg", cfg_data, 8'h03);

    // repeated start: write then read, no STOP between
    base_v = vld_cnt;
    sample_data = 12'h3C7;
    i2c_start;
    wr_byte(8'h90, ack);
    wr_byte(8'h02, a2);
    chk("rs_wr_acks", {ack, a2}, 2'b11);
    i2c_start;
    wr_byte(8'h91, ack);
    chk("rs_rd_ack", ack, 1);
    rd_byte(1'b1, b0);
    rd_byte(1'b0, b1);
    i2c_stop;
    chk("rs_cfg", cfg_data, 8'h02);
    chk("rs_pulses", vld_cnt - base_v, 1);
    chk("rs_b0", b0, 8'h03);
    chk("rs_b1", b1, 8'hC7);

    // reset during bit 4 of read byte 0 (byte 0 = 0x00, slave holds SDA low)
    sample_data = 12'h0F0;
    i2c_start;
    wr_byte(8'h91, ack);
    chk("rr_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) rd_bit(v);
    #50 sda_m = 1'b1;
    #150 scl = 1'b1;
    #100 chk("rr_oe_before", sda_oe, 1);
    rst = 1'b0;
    #1 chk("rr_oe_async", sda_oe, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cfg", cfg_data, 8'h00);
    #99 scl = 1'b0;
    #100 rst = 1'b1;
    #200 scl = 1'b1;
    #300 chk("rr_idle_busy", busy, 0);
    chk("rr_idle_oe", sda_oe, 0);
    base_v = vld_cnt;
    i2c_start;
    wr_byte(8'h90, ack);
    wr_byte(8'h77, a2);
    i2c_stop;
    chk("rr_acks", {ack, a2}, 2'b11);
    chk("rr_cfg_after", cfg_data, 8'h77);
    chk("rr_pulses", vld_cnt - base_v, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_adc_responder.md
I2C_ADC_RESPONDER -- requirements
Module: i2c_adc_responder

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h48, giving the 7-bit I2C target address it answers.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops on scl_in and sda_in (allowed range 2..3).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port scl_in, input, 1 bit: the I2C SCL line as sampled from the pad.
REQ-006 The block SHALL have port sda_in, input, 1 bit: the I2C SDA line as sampled from the pad.
REQ-007 The block SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 The block SHALL have port sample_data, input, 12 bits: the conversion value to be served to the I2C master.
REQ-009 The block SHALL have port cfg_data, output, 8 bits: the last configuration byte written by the master (bits [1:0] are the channel select).
REQ-010 The block SHALL have port cfg_valid, output, 1 bit: a 1-clk pulse when cfg_data updates.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 from an address match until the next STOP or START.

Function
REQ-012 scl_in and sda_in SHALL pass through SYNC_STAGES flops, plus one history flop used for edge detection; all decisions use the synchronized values only.
REQ-013 START SHALL be detected when synchronized SDA falls while synchronized SCL is 1.
REQ-014 STOP SHALL be detected when synchronized SDA rises while synchronized SCL is 1.
REQ-015 START and STOP SHALL take priority over bit processing in any state.
REQ-016 Data bits SHALL be sampled on the synchronized SCL rising edge, MSB first.
REQ-017 sda_oe SHALL change only on the clk following a synchronized SCL falling edge, or on START/STOP (release).
REQ-018 The state machine SHALL have these states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-019 START SHALL go to ADDR from any state (including a repeated start) and clear the bit counter.
REQ-020 STOP SHALL go to IDLE from any state and release sda_oe.
REQ-021 In ADDR, after 8 bits: if bits[7:1]==DEV_ADDR the FSM SHALL go to ADDR_ACK and drive sda_oe=1 for the 9th SCL period; otherwise it SHALL go to WAIT_STOP with sda_oe=0 (NACK).
REQ-022 ADDR_ACK SHALL take R/W=0 to WR_DATA and R/W=1 to RD_DATA.
REQ-023 On R/W=1, sample_data SHALL be latched into a 12-bit shadow register at the ADDR_ACK falling edge.
REQ-024 In WR_DATA, after 8 bits the FSM SHALL load cfg_data, pulse cfg_valid for exactly 1 clk, and ACK in WR_ACK.
REQ-025 Further write bytes SHALL each overwrite cfg_data; the last byte wins.
REQ-026 In RD_DATA, byte 0 SHALL be {4'b0000, shadow[11:8]} and byte 1 SHALL be shadow[7:0].
REQ-027 In RD_DATA, sda_oe SHALL equal the inverse of the current bit; SDA is released after bit 0.
REQ-028 In RD_ACK, a master ACK (SDA=0) SHALL continue to the next byte; after byte 1 it SHALL relatch sample_data and return to byte 0.
REQ-029 In RD_ACK, a master NACK SHALL go to WAIT_STOP with SDA released.
REQ-030 In WAIT_STOP, sda_oe SHALL be 0 and the block SHALL ignore SCL until START or STOP.
REQ-031 Bit counter: 3 bits; wraps 7->0 at each ACK slot.
REQ-032 sample_data changes mid-byte SHALL NOT affect bits already in flight.

Reset
REQ-033 While rst=0, state=IDLE, sda_oe=0, cfg_data=8'h00, cfg_valid=0, busy=0, shadow=12'h000, and the synchronizers SHALL be set to 1 (bus idle).
REQ-034 Reset deassertion mid-transfer SHALL leave the block in IDLE until a fresh START; no spurious START or STOP is detected from synchronizer preset values.

Verification
REQ-035 The bench SHALL check a write: START, 0x90, 0x03, STOP -> ACK on both bytes, cfg_data=0x03, exactly one cfg_valid pulse, busy falls after STOP.
REQ-036 The bench SHALL check a read: sample_data=12'hA5C, START, 0x91, master ACK then NACK, STOP -> bytes 0x0A and 0x5C on SDA, then SDA released.
REQ-037 The bench SHALL check a streaming read: 4 bytes all ACKed, with sample_data changed from 12'h123 to 12'h456 during byte 0 -> 0x01, 0x23, 0x04, 0x56.
REQ-038 The bench SHALL check a wrong address: START, 0xA0, STOP -> no ACK, sda_oe stays 0 throughout, busy stays 0, cfg_data unchanged.
REQ-039 The bench SHALL check a repeated start: START, 0x90, 0x02, RSTART, 0x91, read 2 bytes -> cfg_data=0x02, correct read data, no STOP needed between.
REQ-040 The bench SHALL check reset mid-read: rst=0 during bit 4 of byte 0 -> sda_oe=0 immediately, state IDLE, next transaction completes normally.
